// File: rtl/dbg_ocimem_ctrl_if.sv
// Debug-side and CPU-side signals of the OCI debug memory controller.
// The controller is the slave; the debug slave and the Avalon fabric together form the master.
interface dbg_ocimem_ctrl_if;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [8:0]  cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_readdatavalid;
    logic        cpu_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    modport master (
        output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        output cpu_address, cpu_read, cpu_write, cpu_writedata,
        input  cpu_readdata, cpu_readdatavalid, cpu_waitrequest,
        input  MonDReg, monitor_ready, monitor_error
    );

    modport slave (
        input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        input  cpu_address, cpu_read, cpu_write, cpu_writedata,
        output cpu_readdata, cpu_readdatavalid, cpu_waitrequest,
        output MonDReg, monitor_ready, monitor_error
    );
endinterface

// File: rtl/dbg_ocimem_ctrl.sv
// OCI debug RAM controller: JTAG strobes read/write a single-port debug RAM,
// with an Avalon-MM CPU port sharing the same port at lower priority.
module dbg_ocimem_ctrl #(
    parameter int    DEPTH     = 256,
    parameter string INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             reset,
    dbg_ocimem_ctrl_if.slave bus
);
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [9:0] DEPTH_L = 10'(DEPTH);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAP} state_t;

    state_t      state_reg, state_next;
    logic [8:0]  mon_addr_reg, mon_addr_next;
    logic [31:0] mon_data_reg;
    logic        mon_ready_reg, mon_error_reg;
    logic        rd_oor_reg;
    logic        cpu_rd_p1_reg, cpu_oor_p1_reg;
    logic [31:0] cpu_rdata_reg;
    logic        cpu_rvalid_reg;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] ram_q;
    logic [8:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;

    logic jtag_rd, jtag_wr, err_set, err_clr, rdy_clr;
    logic strobe_any, cpu_wait, cpu_acc, cpu_wr, cpu_rd;
    logic jdo_unused;

    function automatic logic in_range(input logic [8:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    assign jdo_unused = ^{bus.jdo[37], bus.jdo[2:0]};
    assign strobe_any = bus.take_action_ocimem_a | bus.take_no_action_ocimem_a |
                        bus.take_action_ocimem_b;

    always_comb begin
        state_next    = state_reg;
        mon_addr_next = mon_addr_reg;
        ram_addr      = bus.cpu_address;
        jtag_rd       = 1'b0;
        jtag_wr       = 1'b0;
        err_set       = 1'b0;
        err_clr       = 1'b0;
        rdy_clr       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.take_action_ocimem_b) begin
                    ram_addr      = mon_addr_reg;
                    jtag_wr       = in_range(mon_addr_reg);
                    err_set       = !in_range(mon_addr_reg) | bus.take_action_ocimem_a |
                                    bus.take_no_action_ocimem_a;
                    mon_addr_next = mon_addr_reg + 9'd1;
                end else if (bus.take_action_ocimem_a) begin
                    mon_addr_next = bus.jdo[25:17];
                    rdy_clr       = 1'b1;
                    err_clr       = bus.jdo[36];
                    err_set       = bus.take_no_action_ocimem_a;
                    if (bus.jdo[35]) begin
                        ram_addr   = bus.jdo[25:17];
                        jtag_rd    = 1'b1;
                        err_set    = bus.take_no_action_ocimem_a | !in_range(bus.jdo[25:17]);
                        state_next = RD_WAIT;
                    end
                end else if (bus.take_no_action_ocimem_a) begin
                    ram_addr      = mon_addr_reg;
                    rdy_clr       = 1'b1;
                    jtag_rd       = 1'b1;
                    err_set       = !in_range(mon_addr_reg);
                    mon_addr_next = mon_addr_reg + 9'd1;
                    state_next    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                err_set    = strobe_any;
                state_next = RD_CAP;
            end
            RD_CAP: begin
                err_set    = strobe_any;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The CPU only reaches the RAM port in cycles the JTAG side leaves idle.
    assign cpu_wait  = (state_reg != IDLE) | strobe_any | cpu_rd_p1_reg;
    assign cpu_acc   = !cpu_wait & !reset;
    assign cpu_wr    = cpu_acc & bus.cpu_write;
    assign cpu_rd    = cpu_acc & bus.cpu_read & !bus.cpu_write;
    assign ram_we    = !reset & (jtag_wr | (cpu_wr & in_range(bus.cpu_address)));
    assign ram_wdata = jtag_wr ? bus.jdo[34:3] : bus.cpu_writedata;

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_addr[AW-1:0]] <= ram_wdata;
        ram_q <= mem[ram_addr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            mon_addr_reg   <= '0;
            mon_data_reg   <= '0;
            mon_ready_reg  <= 1'b0;
            mon_error_reg  <= 1'b0;
            rd_oor_reg     <= 1'b0;
            cpu_rd_p1_reg  <= 1'b0;
            cpu_oor_p1_reg <= 1'b0;
            cpu_rdata_reg  <= '0;
            cpu_rvalid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mon_addr_reg <= mon_addr_next;
            if (jtag_rd)
                rd_oor_reg <= !in_range(ram_addr);
            // RAM output for the read issued in IDLE is present during RD_WAIT.
            if (state_reg == RD_WAIT) begin
                mon_data_reg  <= rd_oor_reg ? 32'hDEADBEEF : ram_q;
                mon_ready_reg <= 1'b1;
            end else if (rdy_clr) begin
                mon_ready_reg <= 1'b0;
            end
            if (err_clr)
                mon_error_reg <= 1'b0;
            else if (err_set)
                mon_error_reg <= 1'b1;
            cpu_rd_p1_reg  <= cpu_rd;
            cpu_oor_p1_reg <= !in_range(bus.cpu_address);
            cpu_rvalid_reg <= cpu_rd_p1_reg;
            if (cpu_rd_p1_reg)
                cpu_rdata_reg <= cpu_oor_p1_reg ? 32'h0 : ram_q;
        end
    end

    assign bus.MonDReg           = mon_data_reg;
    assign bus.monitor_ready     = mon_ready_reg;
    assign bus.monitor_error     = mon_error_reg;
    assign bus.cpu_readdata      = cpu_rdata_reg;
    assign bus.cpu_readdatavalid = cpu_rvalid_reg;
    assign bus.cpu_waitrequest   = cpu_wait;
endmodule
